// File: rtl/alu_share_arb_if.sv
// Bundle of request, shared-ALU and response signals for alu_share_arb.
// The arbiter uses the slave modport; a requester/ALU/consumer environment
// uses the master modport.
interface alu_share_arb_if #(
    parameter int TAG_W = 4
);
    // requester 0 (EXE pipeline)
    logic             r0_valid;
    logic             r0_ready;
    logic [3:0]       r0_opc;
    logic             r0_sel_pc;
    logic [31:0]      r0_pc;
    logic [31:0]      r0_reg1;
    logic [31:0]      r0_src2;
    logic [TAG_W-1:0] r0_tag;

    // requester 1 (auxiliary address/compare unit)
    logic             r1_valid;
    logic             r1_ready;
    logic [3:0]       r1_opc;
    logic             r1_sel_pc;
    logic [31:0]      r1_pc;
    logic [31:0]      r1_reg1;
    logic [31:0]      r1_src2;
    logic [TAG_W-1:0] r1_tag;

    // shared combinational ALU
    logic [3:0]       alu_opc;
    logic             alu_sel_pc;
    logic [31:0]      alu_pc;
    logic [31:0]      alu_reg1;
    logic [31:0]      alu_src2;
    logic [31:0]      alu_result;

    // response channel
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    logic [31:0]      rsp_data;

    modport slave (
        input  r0_valid, r0_opc, r0_sel_pc, r0_pc, r0_reg1, r0_src2, r0_tag,
        output r0_ready,
        input  r1_valid, r1_opc, r1_sel_pc, r1_pc, r1_reg1, r1_src2, r1_tag,
        output r1_ready,
        output alu_opc, alu_sel_pc, alu_pc, alu_reg1, alu_src2,
        input  alu_result,
        output rsp_valid, rsp_id, rsp_tag, rsp_data,
        input  rsp_ready
    );

    modport master (
        output r0_valid, r0_opc, r0_sel_pc, r0_pc, r0_reg1, r0_src2, r0_tag,
        input  r0_ready,
        output r1_valid, r1_opc, r1_sel_pc, r1_pc, r1_reg1, r1_src2, r1_tag,
        input  r1_ready,
        input  alu_opc, alu_sel_pc, alu_pc, alu_reg1, alu_src2,
        output alu_result,
        input  rsp_valid, rsp_id, rsp_tag, rsp_data,
        output rsp_ready
    );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one combinational RV32I ALU between the EXE
// pipeline (requester 0) and an auxiliary address/compare unit (requester 1).
// The granted request drives the ALU; its result is captured in a single
// response register so a result appears exactly one cycle after acceptance.
// Optional macro ALU_ARB_STATS_EN adds accept/stall counters.
module alu_share_arb #(
    parameter int TAG_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    alu_share_arb_if.slave bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [31:0] stat_gnt0,
    output logic [31:0] stat_gnt1,
    output logic [31:0] stat_stall
`endif
);

    logic             rsp_valid_reg;
    logic             rsp_id_reg;
    logic [TAG_W-1:0] rsp_tag_reg;
    logic [31:0]      rsp_data_reg;
    logic             last_grant_reg;

    logic             can_issue;
    logic             has_grant;
    logic             gnt;
    logic             accept;
    logic [TAG_W-1:0] gnt_tag;

    // Output stage is free when empty or being drained this cycle.
    assign can_issue = !rsp_valid_reg || bus.rsp_ready;

    // Round-robin grant: contention goes to whoever did not win last.
    always_comb begin
        has_grant = bus.r0_valid | bus.r1_valid;
        gnt       = 1'b0;
        if (bus.r0_valid && bus.r1_valid)
            gnt = ~last_grant_reg;
        else if (bus.r1_valid)
            gnt = 1'b1;
    end

    // Readies are held low during reset so nothing is accepted then.
    assign accept       = reset && can_issue && has_grant;
    assign bus.r0_ready = accept && !gnt;
    assign bus.r1_ready = accept && gnt;
    assign gnt_tag      = gnt ? bus.r1_tag : bus.r0_tag;

    // Mux the granted request onto the ALU even while stalled; zeros otherwise.
    always_comb begin
        bus.alu_opc    = 4'd0;
        bus.alu_sel_pc = 1'b0;
        bus.alu_pc     = 32'd0;
        bus.alu_reg1   = 32'd0;
        bus.alu_src2   = 32'd0;
        if (has_grant) begin
            if (gnt) begin
                bus.alu_opc    = bus.r1_opc;
                bus.alu_sel_pc = bus.r1_sel_pc;
                bus.alu_pc     = bus.r1_pc;
                bus.alu_reg1   = bus.r1_reg1;
                bus.alu_src2   = bus.r1_src2;
            end else begin
                bus.alu_opc    = bus.r0_opc;
                bus.alu_sel_pc = bus.r0_sel_pc;
                bus.alu_pc     = bus.r0_pc;
                bus.alu_reg1   = bus.r0_reg1;
                bus.alu_src2   = bus.r0_src2;
            end
        end
    end

    // Response register: load on accept (replacing a drained entry in the
    // same edge), clear valid on a plain drain, otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= 1'b0;
            rsp_tag_reg    <= '0;
            rsp_data_reg   <= 32'd0;
            last_grant_reg <= 1'b1;
        end else if (accept) begin
            rsp_valid_reg  <= 1'b1;
            rsp_id_reg     <= gnt;
            rsp_tag_reg    <= gnt_tag;
            rsp_data_reg   <= bus.alu_result;
            last_grant_reg <= gnt;
        end else if (rsp_valid_reg && bus.rsp_ready) begin
            rsp_valid_reg  <= 1'b0;
        end
    end

    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_id    = rsp_id_reg;
    assign bus.rsp_tag   = rsp_tag_reg;
    assign bus.rsp_data  = rsp_data_reg;

`ifdef ALU_ARB_STATS_EN
    // Wrapping counters of accepts per requester and of stalled request cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_gnt0  <= 32'd0;
            stat_gnt1  <= 32'd0;
            stat_stall <= 32'd0;
        end else begin
            if (accept && !gnt)
                stat_gnt0 <= stat_gnt0 + 32'd1;
            if (accept && gnt)
                stat_gnt1 <= stat_gnt1 + 32'd1;
            if (has_grant && !accept)
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed testbench for alu_share_arb. A small behavioural RV32I ALU drives
// alu_result from the arbiter's alu_* outputs. Build with +define+ALU_ARB_STATS_EN
// to also exercise the statistics counters.
module tb_alu_share_arb;

    localparam int TAG_W = 4;

    // ALU sub-opcode encoding used by the stand-in ALU.
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    alu_share_arb_if #(.TAG_W(TAG_W)) bus ();

`ifdef ALU_ARB_STATS_EN
    logic [31:0] stat_gnt0;
    logic [31:0] stat_gnt1;
    logic [31:0] stat_stall;
`endif

    alu_share_arb #(.TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef ALU_ARB_STATS_EN
        ,
        .stat_gnt0  (stat_gnt0),
        .stat_gnt1  (stat_gnt1),
        .stat_stall (stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in shared ALU (combinational).
    logic [31:0] op1;
    always_comb begin
        op1 = bus.alu_sel_pc ? bus.alu_pc : bus.alu_reg1;
        case (bus.alu_opc)
            OP_ADD:  bus.alu_result = op1 + bus.alu_src2;
            OP_SUB:  bus.alu_result = op1 - bus.alu_src2;
            OP_AND:  bus.alu_result = op1 & bus.alu_src2;
            OP_OR:   bus.alu_result = op1 | bus.alu_src2;
            OP_XOR:  bus.alu_result = op1 ^ bus.alu_src2;
            OP_SLT:  bus.alu_result = {31'd0, $signed(op1) < $signed(bus.alu_src2)};
            OP_SLTU: bus.alu_result = {31'd0, op1 < bus.alu_src2};
            OP_SLL:  bus.alu_result = op1 << bus.alu_src2[4:0];
            OP_SRL:  bus.alu_result = op1 >> bus.alu_src2[4:0];
            OP_SRA:  bus.alu_result = $unsigned($signed(op1) >>> bus.alu_src2[4:0]);
            default: bus.alu_result = 32'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_r0(input logic v, input logic [3:0] opc, input logic sel_pc,
                          input logic [31:0] pc, input logic [31:0] reg1,
                          input logic [31:0] src2, input logic [TAG_W-1:0] tag);
        bus.r0_valid  = v;
        bus.r0_opc    = opc;
        bus.r0_sel_pc = sel_pc;
        bus.r0_pc     = pc;
        bus.r0_reg1   = reg1;
        bus.r0_src2   = src2;
        bus.r0_tag    = tag;
    endtask

    task automatic set_r1(input logic v, input logic [3:0] opc, input logic sel_pc,
                          input logic [31:0] pc, input logic [31:0] reg1,
                          input logic [31:0] src2, input logic [TAG_W-1:0] tag);
        bus.r1_valid  = v;
        bus.r1_opc    = opc;
        bus.r1_sel_pc = sel_pc;
        bus.r1_pc     = pc;
        bus.r1_reg1   = reg1;
        bus.r1_src2   = src2;
        bus.r1_tag    = tag;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus.rsp_ready = 1'b0;
        set_r0(1'b1, OP_ADD, 1'b0, 32'd0, 32'd1, 32'd1, 4'd0);
        set_r1(1'b0, OP_ADD, 1'b0, 32'd0, 32'd0, 32'd0, 4'd0);

        // Reset state; readies low even with a valid request.
        tick();
        tick();
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
        check("rst_rsp_tag",   32'(bus.rsp_tag),   32'd0);
        check("rst_rsp_data",  bus.rsp_data,       32'd0);
        check("rst_r0_ready",  32'(bus.r0_ready),  32'd0);
        bus.r0_valid = 1'b0;
        reset = 1'b1;
        settle();
        check("idle_alu_opc",  32'(bus.alu_opc),   32'd0);
        check("idle_alu_reg1", bus.alu_reg1,       32'd0);

        // Continuous contention: strict alternation starting with r0.
        bus.rsp_ready = 1'b1;
        set_r0(1'b1, OP_ADD, 1'b0, 32'd0, 32'd10, 32'd20, 4'd1);
        set_r1(1'b1, OP_XOR, 1'b0, 32'd0, 32'hF0, 32'hFF, 4'd2);
        settle();
        check("rr_first_r0_ready", 32'(bus.r0_ready), 32'd1);
        check("rr_first_r1_ready", 32'(bus.r1_ready), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("rr_valid_%0d", i), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("rr_id_%0d", i),    32'(bus.rsp_id),    32'(i % 2));
            check($sformatf("rr_tag_%0d", i),   32'(bus.rsp_tag),   (i % 2 == 0) ? 32'd1 : 32'd2);
            check($sformatf("rr_data_%0d", i),  bus.rsp_data,       (i % 2 == 0) ? 32'd30 : 32'h0F);
        end
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        tick();
        check("rr_drain_valid", 32'(bus.rsp_valid), 32'd0);

        // Single r0 ADD: ready same cycle, result next cycle.
        set_r0(1'b1, OP_ADD, 1'b0, 32'd0, 32'd5, 32'd7, 4'd3);
        settle();
        check("add_r0_ready", 32'(bus.r0_ready), 32'd1);
        check("add_r1_ready", 32'(bus.r1_ready), 32'd0);
        tick();
        bus.r0_valid = 1'b0;
        check("add_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("add_rsp_data",  bus.rsp_data,       32'd12);
        check("add_rsp_id",    32'(bus.rsp_id),    32'd0);
        check("add_rsp_tag",   32'(bus.rsp_tag),   32'd3);
        tick();
        check("add_drain_valid", 32'(bus.rsp_valid), 32'd0);

        // Stall: r1 SUB with PC operand wins (last grant was r0), then held.
        bus.rsp_ready = 1'b0;
        set_r0(1'b1, OP_OR,  1'b0, 32'd0,     32'd1, 32'd2, 4'd5);
        set_r1(1'b1, OP_SUB, 1'b1, 32'h100,   32'd0, 32'd4, 4'd6);
        settle();
        check("stall_r1_ready_first", 32'(bus.r1_ready), 32'd1);
        tick();
        bus.r1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("stall_data_%0d", i),  bus.rsp_data,       32'h0000_00FC);
            check($sformatf("stall_id_%0d", i),    32'(bus.rsp_id),    32'd1);
            check($sformatf("stall_r0rdy_%0d", i), 32'(bus.r0_ready),  32'd0);
            check($sformatf("stall_r1rdy_%0d", i), 32'(bus.r1_ready),  32'd0);
            check($sformatf("stall_alu_%0d", i),   32'(bus.alu_opc),   32'(OP_OR));
            tick();
        end
        bus.rsp_ready = 1'b1;
        settle();
        check("unstall_r0_ready", 32'(bus.r0_ready), 32'd1);
        tick();
        bus.r0_valid = 1'b0;
        check("unstall_rsp_id",   32'(bus.rsp_id),  32'd0);
        check("unstall_rsp_data", bus.rsp_data,     32'd3);
        check("unstall_rsp_tag",  32'(bus.rsp_tag), 32'd5);
        tick();

        // Back-to-back SRA then SLTU from different requesters.
        set_r0(1'b1, OP_SRA, 1'b0, 32'd0, 32'h8000_0000, 32'd4, 4'd7);
        tick();
        check("sra_data", bus.rsp_data,    32'hF800_0000);
        check("sra_id",   32'(bus.rsp_id), 32'd0);
        bus.r0_valid = 1'b0;
        set_r1(1'b1, OP_SLTU, 1'b0, 32'd0, 32'd1, 32'hFFFF_FFFF, 4'd8);
        settle();
        check("sltu_r1_ready", 32'(bus.r1_ready), 32'd1);
        tick();
        bus.r1_valid = 1'b0;
        check("sltu_valid", 32'(bus.rsp_valid), 32'd1);
        check("sltu_data",  bus.rsp_data,       32'd1);
        check("sltu_id",    32'(bus.rsp_id),    32'd1);
        tick();

        // Pending response discarded by reset; priority returns to r0.
        bus.rsp_ready = 1'b0;
        set_r0(1'b1, OP_ADD, 1'b0, 32'd0, 32'd2, 32'd2, 4'd9);
        tick();
        check("pend_valid", 32'(bus.rsp_valid), 32'd1);
        reset = 1'b0;
        settle();
        check("areset_valid",    32'(bus.rsp_valid), 32'd0);
        check("areset_data",     bus.rsp_data,       32'd0);
        check("areset_r0_ready", 32'(bus.r0_ready),  32'd0);
        tick();
        reset = 1'b1;
        bus.rsp_ready = 1'b1;
        set_r1(1'b1, OP_ADD, 1'b0, 32'd0, 32'd3, 32'd3, 4'd10);
        settle();
        check("post_rst_r0_ready", 32'(bus.r0_ready), 32'd1);
        check("post_rst_r1_ready", 32'(bus.r1_ready), 32'd0);
        tick();
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        check("post_rst_id",   32'(bus.rsp_id),  32'd0);
        check("post_rst_data", bus.rsp_data,     32'd4);
        tick();

`ifdef ALU_ARB_STATS_EN
        // Counters: 4 r0 accepts, 2 r1 accepts, 3 stalled cycles.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("stat_rst_gnt0", stat_gnt0, 32'd0);
        bus.rsp_ready = 1'b1;
        set_r0(1'b1, OP_ADD, 1'b0, 32'd0, 32'd1, 32'd1, 4'd1);
        for (int i = 0; i < 4; i++) tick();
        bus.r0_valid = 1'b0;
        set_r1(1'b1, OP_ADD, 1'b0, 32'd0, 32'd1, 32'd1, 4'd2);
        for (int i = 0; i < 2; i++) tick();
        bus.r1_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.r0_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        bus.r0_valid = 1'b0;
        tick();
        check("stat_gnt0",  stat_gnt0,  32'd4);
        check("stat_gnt1",  stat_gnt1,  32'd2);
        check("stat_stall", stat_stall, 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one combinational RV32I ALU (AND/OR/XOR, ADD/SUB, SLT/SLTU, SLL/SRL/SRA; opcodes from params.v) between two requesters:
  - requester 0: EXE pipeline.
  - requester 1: auxiliary address/compare unit.
- Round-robin arbitration with valid/ready handshakes on each request port.
- Drives the shared ALU's inputs, registers its result, and returns the result with requester id and tag on a single valid/ready response channel.

Parameters:
TAG_W, 4, width of the opaque tag carried from request to response.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
r0_valid  in  1  requester 0 request valid
r0_ready  out  1  requester 0 request accepted this cycle (when r0_valid)
r0_opc  in  4  ALU sub-opcode
r0_sel_pc  in  1  1 selects PC as operand 1, 0 selects reg1
r0_pc  in  32  PC operand
r0_reg1  in  32  rs1 operand
r0_src2  in  32  operand 2
r0_tag  in  TAG_W  request tag
r1_valid, r1_ready, r1_opc, r1_sel_pc, r1_pc, r1_reg1, r1_src2, r1_tag  same as r0_*, for requester 1
alu_opc  out  4  to shared ALU exe_alu_opc_r
alu_sel_pc  out  1  to shared ALU exe_sel_pc_r
alu_pc  out  32  to shared ALU exe_pc_r
alu_reg1  out  32  to shared ALU exe_reg1_r
alu_src2  out  32  to shared ALU exe_src2_r
alu_result  in  32  from shared ALU (combinational)
rsp_valid  out  1  response register holds a result
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that issued the result
rsp_tag  out  TAG_W  tag of that request
rsp_data  out  32  registered ALU result

Behaviour:
- Reset (reset==0, async): rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_data=0, last_grant=1 (requester 0 wins first contention). r0_ready=r1_ready=0 while in reset.
- can_issue = !rsp_valid || rsp_ready (single output stage, full-throughput pipeline).
- Grant (combinational):
  - Only r0_valid → gnt=0.
  - Only r1_valid → gnt=1.
  - Both valid → gnt = ~last_grant.
  - Neither valid → no grant.
- rX_ready = can_issue && grant to X. At most one ready high per cycle.
- ALU drive:
  - Granted request's fields are muxed onto alu_* whenever a grant exists, even when can_issue=0.
  - No grant → alu_* all zero (opcode 0).
- Accept (valid && ready) in cycle N:
  - rsp_data <= alu_result, rsp_id <= gnt, rsp_tag <= tag, rsp_valid <= 1, last_grant <= gnt.
  - Response visible in cycle N+1. Latency is exactly 1 cycle.
- rsp_valid && rsp_ready with no accept → rsp_valid <= 0; other response fields hold.
- rsp_valid && !rsp_ready → all response fields hold. No new accept; both readies 0.
- Simultaneous drain and accept → new response replaces old in the same edge. No bubble, sustained 1 result/cycle.
- last_grant updates only on an accepted transfer. A stalled contention does not rotate priority.
- Fairness: with both valid continuously, grants strictly alternate. Each requester waits at most 1 accepted transfer.
- Requesters must hold fields stable while valid && !ready. The block does not check this.
- Opcodes pass through unchecked. Undefined opcodes yield whatever the ALU returns.
- Reset asserted mid-stall: pending response is discarded, no response is emitted for it.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- When defined, adds three outputs, all 32-bit wrapping counters cleared on reset:
  - stat_gnt0: accepts for requester 0.
  - stat_gnt1: accepts for requester 1.
  - stat_stall: cycles with any rX_valid and no accept.
- When undefined, these ports and counters do not exist. Core behaviour is identical either way.

Test Plan:
- Only r0 valid, ADD, reg1=5, src2=7, sel_pc=0, tag=3 → r0_ready=1 same cycle; next cycle rsp_valid=1, rsp_data=12, rsp_id=0, rsp_tag=3.
- Both valid continuously for 6 accepts, rsp_ready=1 → rsp_id sequence 0,1,0,1,0,1 with back-to-back rsp_valid.
- r1 SUB, sel_pc=1, pc=0x100, src2=4, rsp_ready=0 for 3 cycles, r0 also valid:
  - rsp_data=0x000000FC held 3 cycles, both readies 0.
  - On rsp_ready=1 the next grant is r0.
- r0 SRA reg1=0x80000000 src2=4, then r1 SLTU reg1=1 src2=0xFFFFFFFF → rsp_data 0xF8000000 then 1.
- Pending response with rsp_ready=0, assert reset → rsp_valid=0 immediately; after release, both valid → r0 granted first.
- With ALU_ARB_STATS_EN: 4 r0 accepts, 2 r1 accepts, 3 stalled cycles → stat_gnt0=4, stat_gnt1=2, stat_stall=3.
